// File: rtl/coord_entry_ctrl.sv
// Coordinate-entry controller: conditions three active-low buttons, assembles an
// X then Y coordinate bit-serially, and range-checks the pair on confirmation.
module coord_entry_ctrl #(
   parameter int COORD_W         = 4,
   parameter int MAX_X           = 9,
   parameter int MAX_Y           = 9,
   parameter bit LSB_FIRST       = 1'b1,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               btn0_n,
   input  logic                               btn1_n,
   input  logic                               act_n,
   output logic [COORD_W-1:0]                 x_out,
   output logic [COORD_W-1:0]                 y_out,
   output logic [$clog2(COORD_W+1)-1:0]       bit_count,
   output logic                               coord_valid,
   output logic                               coord_error,
   output logic [1:0]                         state
);

   localparam int BCW = $clog2(COORD_W + 1);
   localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TCW-1:0] TMO_LIMIT  = TCW'(TIMEOUT_CYCLES);
   localparam logic [BCW-1:0] BITS_LIMIT = BCW'(COORD_W);

   // A bound at or above the all-ones value can never be exceeded.
   localparam bit X_ALWAYS_OK = (MAX_X >= (2 ** COORD_W) - 1);
   localparam bit Y_ALWAYS_OK = (MAX_Y >= (2 ** COORD_W) - 1);
   localparam logic [COORD_W-1:0] MAX_X_W = X_ALWAYS_OK ? '1 : COORD_W'(MAX_X);
   localparam logic [COORD_W-1:0] MAX_Y_W = Y_ALWAYS_OK ? '1 : COORD_W'(MAX_Y);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      X_IN    = 2'd1,
      Y_IN    = 2'd2,
      CONFIRM = 2'd3
   } state_t;

   logic [2:0]     raw_n;
   logic [2:0]     sync1_q, sync1_d;
   logic [2:0]     sync2_q, sync2_d;
   logic [2:0]     deb_q, deb_d;
   logic [2:0]     press_q, press_d;
   logic [DCW-1:0] deb_cnt_q [3];
   logic [DCW-1:0] deb_cnt_d [3];

   state_t         state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic [BCW-1:0] cnt_q, cnt_d;
   logic           valid_q, valid_d;
   logic           error_q, error_d;
   logic [TCW-1:0] tmo_q, tmo_d;

   logic           bit_press;
   logic           bit_val;
   logic           act_press;
   logic           any_press;
   logic [BCW-1:0] cnt_inc;
   logic           axis_done;
   logic [TCW-1:0] tmo_inc;
   logic           timeout;
   logic           x_ok;
   logic           y_ok;

   assign raw_n = {act_n, btn1_n, btn0_n};

   function automatic logic [COORD_W-1:0] shift_in(input logic [COORD_W-1:0] r,
                                                   input logic b);
      logic [COORD_W-1:0] res;
      if (LSB_FIRST) begin
         res = r >> 1;
         res[COORD_W-1] = b;
      end else begin
         res = r << 1;
         res[0] = b;
      end
      return res;
   endfunction

   // Level changes are accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      sync1_d   = raw_n;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      press_d   = '0;
      deb_cnt_d = '{default: '0};
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
            end
         end
         press_d[i] = deb_q[i] & ~deb_d[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         press_q <= '0;
         for (int i = 0; i < 3; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         press_q   <= press_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   assign bit_press = press_q[0] ^ press_q[1];
   assign bit_val   = press_q[1];
   assign act_press = press_q[2];
   assign any_press = |press_q;
   assign cnt_inc   = cnt_q + BCW'(1);
   assign axis_done = (cnt_inc == BITS_LIMIT);
   assign tmo_inc   = tmo_q + TCW'(1);
   assign x_ok      = (x_q <= MAX_X_W);
   assign y_ok      = (y_q <= MAX_Y_W);

   // Any press event keeps the entry alive, so timeout cannot coincide with an act press.
   assign timeout = (TIMEOUT_CYCLES > 0) && (state_q != IDLE) && !any_press &&
                    (tmo_inc == TMO_LIMIT);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      tmo_d   = tmo_inc;

      if ((TIMEOUT_CYCLES == 0) || (state_q == IDLE) || any_press || timeout) begin
         tmo_d = '0;
      end

      case (state_q)
         IDLE: begin
            if (bit_press) begin
               x_d = shift_in('0, bit_val);
               y_d = '0;
               if (BITS_LIMIT == BCW'(1)) begin
                  state_d = Y_IN;
                  cnt_d   = '0;
               end else begin
                  state_d = X_IN;
                  cnt_d   = BCW'(1);
               end
            end
         end
         X_IN: begin
            if (act_press) begin
               state_d = IDLE;
               x_d     = '0;
               y_d     = '0;
               cnt_d   = '0;
            end else if (bit_press) begin
               x_d = shift_in(x_q, bit_val);
               if (axis_done) begin
                  state_d = Y_IN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (timeout) begin
               state_d = IDLE;
               x_d     = '0;
               y_d     = '0;
               cnt_d   = '0;
               error_d = 1'b1;
            end
         end
         Y_IN: begin
            if (act_press) begin
               state_d = IDLE;
               x_d     = '0;
               y_d     = '0;
               cnt_d   = '0;
            end else if (bit_press) begin
               y_d = shift_in(y_q, bit_val);
               if (axis_done) begin
                  state_d = CONFIRM;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else if (timeout) begin
               state_d = IDLE;
               x_d     = '0;
               y_d     = '0;
               cnt_d   = '0;
               error_d = 1'b1;
            end
         end
         CONFIRM: begin
            if (act_press) begin
               state_d = IDLE;
               if (x_ok && y_ok) begin
                  valid_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end else if (timeout) begin
               state_d = IDLE;
               x_d     = '0;
               y_d     = '0;
               cnt_d   = '0;
               error_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         error_q <= error_d;
         tmo_q   <= tmo_d;
      end
   end

   assign x_out       = x_q;
   assign y_out       = y_q;
   assign bit_count   = cnt_q;
   assign coord_valid = valid_q;
   assign coord_error = error_q;
   assign state       = state_q;

endmodule

// File: tb/tb_coord_entry_ctrl.sv
// Bench for coord_entry_ctrl: two instances (LSB-first with timeout, MSB-first without)
// share the buttons and are checked against a bit-list reference model.
module tb_coord_entry_ctrl;

   localparam int W    = 4;
   localparam int D    = 4;
   localparam int T    = 100;
   localparam int MAXV = 9;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn0_n = 1'b1;
   logic btn1_n = 1'b1;
   logic act_n = 1'b1;

   logic [W-1:0] x_a, y_a, x_b, y_b;
   logic [2:0]   bc_a, bc_b;
   logic         valid_a, error_a, valid_b, error_b;
   logic [1:0]   st_a, st_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pv_a = 0, pe_a = 0, pv_b = 0, pe_b = 0, p_both = 0;

   int m_state = 0;
   int xbits[$];
   int ybits[$];
   int exp_v_a = 0, exp_e_a = 0, exp_v_b = 0, exp_e_b = 0;

   coord_entry_ctrl #(
      .COORD_W(W), .MAX_X(MAXV), .MAX_Y(MAXV), .LSB_FIRST(1'b1),
      .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)
   ) dut_a (
      .clk(clk), .reset(reset), .btn0_n(btn0_n), .btn1_n(btn1_n), .act_n(act_n),
      .x_out(x_a), .y_out(y_a), .bit_count(bc_a),
      .coord_valid(valid_a), .coord_error(error_a), .state(st_a)
   );

   coord_entry_ctrl #(
      .COORD_W(W), .MAX_X(MAXV), .MAX_Y(MAXV), .LSB_FIRST(1'b0),
      .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(0)
   ) dut_b (
      .clk(clk), .reset(reset), .btn0_n(btn0_n), .btn1_n(btn1_n), .act_n(act_n),
      .x_out(x_b), .y_out(y_b), .bit_count(bc_b),
      .coord_valid(valid_b), .coord_error(error_b), .state(st_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters sampled mid-cycle; a pulse that lasts two cycles counts twice.
   always @(negedge clk) begin
      if (reset) begin
         pv_a <= 0; pe_a <= 0; pv_b <= 0; pe_b <= 0; p_both <= 0;
      end else begin
         if (valid_a) pv_a <= pv_a + 1;
         if (error_a) pe_a <= pe_a + 1;
         if (valid_b) pv_b <= pv_b + 1;
         if (error_b) pe_b <= pe_b + 1;
         if ((valid_a && error_a) || (valid_b && error_b)) p_both <= p_both + 1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit exceeded");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Value held by the register after the listed bits, from their entry positions.
   function automatic int coord_val(input bit is_y, input bit lsb);
      int n;
      int v;
      n = is_y ? ybits.size() : xbits.size();
      v = 0;
      for (int i = 0; i < n; i++) begin
         int b;
         b = is_y ? ybits[i] : xbits[i];
         if (lsb) v += b << (W - n + i);
         else     v += b << (n - 1 - i);
      end
      return v;
   endfunction

   task automatic modelEvent(input int kind);
      if (kind == 0 || kind == 1) begin
         case (m_state)
            0: begin
               xbits.delete();
               ybits.delete();
               xbits.push_back(kind);
               m_state = (xbits.size() == W) ? 2 : 1;
            end
            1: begin
               xbits.push_back(kind);
               if (xbits.size() == W) m_state = 2;
            end
            2: begin
               ybits.push_back(kind);
               if (ybits.size() == W) m_state = 3;
            end
            default: ;
         endcase
      end else if (kind == 3) begin
         if (m_state == 1 || m_state == 2) begin
            xbits.delete();
            ybits.delete();
            m_state = 0;
         end else if (m_state == 3) begin
            if (coord_val(0, 1) <= MAXV && coord_val(1, 1) <= MAXV) exp_v_a++;
            else exp_e_a++;
            if (coord_val(0, 0) <= MAXV && coord_val(1, 0) <= MAXV) exp_v_b++;
            else exp_e_b++;
            m_state = 0;
         end
      end
   endtask

   task automatic checkAll(input string tag);
      int exp_bc;
      exp_bc = (m_state == 1) ? xbits.size() : (m_state == 2) ? ybits.size() : 0;
      checkOutput({tag, ".state_a"}, int'(st_a), m_state);
      checkOutput({tag, ".state_b"}, int'(st_b), m_state);
      checkOutput({tag, ".bc_a"}, int'(bc_a), exp_bc);
      checkOutput({tag, ".bc_b"}, int'(bc_b), exp_bc);
      checkOutput({tag, ".x_a"}, int'(x_a), coord_val(0, 1));
      checkOutput({tag, ".y_a"}, int'(y_a), coord_val(1, 1));
      checkOutput({tag, ".x_b"}, int'(x_b), coord_val(0, 0));
      checkOutput({tag, ".y_b"}, int'(y_b), coord_val(1, 0));
      checkOutput({tag, ".valid_a"}, pv_a, exp_v_a);
      checkOutput({tag, ".error_a"}, pe_a, exp_e_a);
      checkOutput({tag, ".valid_b"}, pv_b, exp_v_b);
      checkOutput({tag, ".error_b"}, pe_b, exp_e_b);
      checkOutput({tag, ".both_pulses"}, p_both, 0);
   endtask

   // kind: 0 = bit0, 1 = bit1, 2 = both bit buttons, 3 = act, 4 = short btn1 glitch
   task automatic applyStimulus(input int kind, input int hold);
      @(negedge clk);
      case (kind)
         0: btn0_n = 1'b0;
         1: btn1_n = 1'b0;
         2: begin btn0_n = 1'b0; btn1_n = 1'b0; end
         3: act_n = 1'b0;
         default: btn1_n = 1'b0;
      endcase
      repeat (hold) @(negedge clk);
      btn0_n = 1'b1;
      btn1_n = 1'b1;
      act_n  = 1'b1;
      repeat (D + 4) @(negedge clk);
      if (kind != 4) modelEvent(kind);
   endtask

   task automatic enterBits(input string tag, input int bits[8], input int count);
      for (int i = 0; i < count; i++) begin
         applyStimulus(bits[i], D + 4);
         checkAll($sformatf("%s.bit%0d", tag, i));
      end
   endtask

   task automatic doReset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput({tag, ".rst_state"}, int'(st_a), 0);
      checkOutput({tag, ".rst_x"}, int'(x_a), 0);
      checkOutput({tag, ".rst_y"}, int'(y_a), 0);
      checkOutput({tag, ".rst_bc"}, int'(bc_a), 0);
      checkOutput({tag, ".rst_valid"}, int'(valid_a), 0);
      checkOutput({tag, ".rst_error"}, int'(error_a), 0);
      checkOutput({tag, ".rst_state_b"}, int'(st_b), 0);
      checkOutput({tag, ".rst_x_b"}, int'(x_b), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_state = 0;
      xbits.delete();
      ybits.delete();
      exp_v_a = 0; exp_e_a = 0; exp_v_b = 0; exp_e_b = 0;
   endtask

   initial begin
      int seq[8];
      int found;
      int t0;
      int t1;
      int kind;
      int hold;
      int r;
      bit last_glitch;

      doReset("init");

      // Valid entry: X 1,0,1,0 -> 5, Y 1,1,0,0 -> 3 (LSB first)
      seq = '{1, 0, 1, 0, 1, 1, 0, 0};
      enterBits("valid", seq, 8);
      applyStimulus(3, D + 4);
      checkAll("valid.act");
      checkOutput("valid.x_const", int'(x_a), 5);
      checkOutput("valid.y_const", int'(y_a), 3);
      checkOutput("valid.pulse_const", pv_a, 1);
      checkOutput("valid.noerr_const", pe_a, 0);

      // Out-of-range X = 15 on both instances
      seq = '{1, 1, 1, 1, 0, 0, 0, 0};
      enterBits("range", seq, 8);
      applyStimulus(3, D + 4);
      checkAll("range.act");
      checkOutput("range.x_const", int'(x_a), 15);

      // MSB-first ordering: X 1,0,0,0 -> 8
      seq = '{1, 0, 0, 0, 0, 0, 0, 0};
      enterBits("msb", seq, 8);
      checkOutput("msb.x_const", int'(x_b), 8);
      checkOutput("msb.x_lsb_const", int'(x_a), 1);
      applyStimulus(3, D + 4);
      checkAll("msb.act");

      // Glitch rejection, long hold, simultaneous bit buttons, then cancel in Y_IN
      applyStimulus(1, D + 4);
      checkAll("glitch.first");
      applyStimulus(4, D - 1);
      checkAll("glitch.after");
      checkOutput("glitch.bc_const", int'(bc_a), 1);
      applyStimulus(0, 50);
      checkAll("hold.after");
      checkOutput("hold.bc_const", int'(bc_a), 2);
      applyStimulus(2, D + 4);
      checkAll("both.after");
      checkOutput("both.bc_const", int'(bc_a), 2);
      seq = '{0, 1, 1, 0, 0, 0, 0, 0};
      enterBits("cancel", seq, 4);
      applyStimulus(3, D + 4);
      checkAll("cancel.act");
      checkOutput("cancel.state_const", int'(st_a), 0);

      // Randomized operations against the model
      doReset("rand");
      last_glitch = 1'b0;
      for (int n = 0; n < 60; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 35)      kind = 0;
         else if (r < 70) kind = 1;
         else if (r < 78) kind = 2;
         else if (r < 92) kind = 3;
         else             kind = 4;
         if (kind == 4 && last_glitch) kind = 1;
         last_glitch = (kind == 4);
         if (kind == 4) hold = int'($urandom_range(1, D - 1));
         else if ($urandom_range(0, 9) == 0) hold = 50;
         else hold = int'($urandom_range(D + 3, D + 8));
         applyStimulus(kind, hold);
         checkAll($sformatf("rand%0d.k%0d", n, kind));
      end

      // Timeout fires exactly T cycles after the last registered press
      doReset("tmo");
      applyStimulus(1, D + 4);
      checkAll("tmo.first");
      @(negedge clk);
      btn0_n = 1'b0;
      found = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
         @(negedge clk);
         if (bc_a == 3'd2) found = 1;
      end
      t0 = cyc;
      checkOutput("tmo.second_bit", found, 1);
      btn0_n = 1'b1;
      found = 0;
      for (int i = 0; i < 2 * T && found == 0; i++) begin
         @(negedge clk);
         if (error_a) found = 1;
      end
      t1 = cyc;
      checkOutput("tmo.seen", found, 1);
      checkOutput("tmo.delay", t1 - t0, T);
      checkOutput("tmo.state", int'(st_a), 0);
      checkOutput("tmo.x", int'(x_a), 0);
      checkOutput("tmo.y", int'(y_a), 0);
      checkOutput("tmo.bc", int'(bc_a), 0);
      repeat (3) @(negedge clk);
      checkOutput("tmo.err_count", pe_a, 1);
      checkOutput("tmo.valid_count", pv_a, 0);

      // An act press landing on the timeout cycle confirms instead
      doReset("tact");
      seq = '{1, 0, 1, 0, 1, 1, 0, 0};
      enterBits("tact", seq, 7);
      @(negedge clk);
      btn0_n = 1'b0;
      found = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
         @(negedge clk);
         if (st_a == 2'd3) found = 1;
      end
      t0 = cyc;
      checkOutput("tact.confirm", found, 1);
      btn0_n = 1'b1;
      while (cyc < t0 + T - D - 3) @(negedge clk);
      act_n = 1'b0;
      found = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
         @(negedge clk);
         if (st_a == 2'd0) found = 1;
      end
      t1 = cyc;
      checkOutput("tact.idle", found, 1);
      checkOutput("tact.delay", t1 - t0, T);
      repeat (D + 4) @(negedge clk);
      act_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("tact.valid_count", pv_a, 1);
      checkOutput("tact.err_count", pe_a, 0);
      checkOutput("tact.x_hold", int'(x_a), 5);
      checkOutput("tact.y_hold", int'(y_a), 3);

      // Reset while waiting in CONFIRM, then a clean valid entry
      doReset("rconf");
      seq = '{1, 0, 1, 0, 1, 1, 0, 0};
      enterBits("rconf", seq, 8);
      checkOutput("rconf.in_confirm", int'(st_a), 3);
      doReset("rconf.mid");
      enterBits("after", seq, 8);
      applyStimulus(3, D + 4);
      checkAll("after.act");
      checkOutput("after.pulse_const", pv_a, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
